// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the pipeline (IF/MEM requesters), the arbiter and the external memory.
// The arbiter uses the slave view; the pipeline/memory side uses the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_abort;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              if_stall;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              mem_stall;
  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic [DATA_W-1:0] ext_rdata;
  logic              ext_ack;

  modport slave (
    input  if_req, if_addr, if_abort, mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
           ext_rdata, ext_ack,
    output if_rdata, if_ready, if_stall, mem_rdata, mem_ready, mem_stall,
           ext_req, ext_we, ext_addr, ext_wdata
  );

  modport master (
    output if_req, if_addr, if_abort, mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
           ext_rdata, ext_ack,
    input  if_rdata, if_ready, if_stall, mem_rdata, mem_ready, mem_stall,
           ext_req, ext_we, ext_addr, ext_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port external memory between fetch (IF) and load/store (MEM).
// MEM has priority; a starvation counter forces an IF grant after STARVE_LIMIT MEM grants.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;

  state_t            state_q, state_d;
  logic              ext_req_q, ext_req_d;
  logic              ext_we_q, ext_we_d;
  logic [ADDR_W-1:0] ext_addr_q, ext_addr_d;
  logic [DATA_W-1:0] ext_wdata_q, ext_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              mem_ready_q, mem_ready_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              abort_q, abort_d;

  logic mem_pend;
  logic force_if;
  logic ready_cycle;

  assign mem_pend    = bus.mem_rd_en | bus.mem_wr_en;
  assign force_if    = bus.if_req & (starve_q == STARVE_MAX);
  // The finished requester still holds its request during the ready pulse, so no grant then.
  assign ready_cycle = if_ready_q | mem_ready_q;

  always_comb begin
    state_d     = state_q;
    ext_req_d   = ext_req_q;
    ext_we_d    = ext_we_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    if_rdata_d  = if_rdata_q;
    if_ready_d  = 1'b0;
    mem_rdata_d = mem_rdata_q;
    mem_ready_d = 1'b0;
    starve_d    = starve_q;
    abort_d     = abort_q;
    case (state_q)
      IDLE: begin
        if (!bus.if_req) starve_d = '0;
        if (!ready_cycle) begin
          if (mem_pend && !force_if) begin
            state_d     = BUSY_MEM;
            ext_req_d   = 1'b1;
            ext_we_d    = bus.mem_wr_en;
            ext_addr_d  = bus.mem_addr;
            ext_wdata_d = bus.mem_wdata;
            if (bus.if_req && (starve_q != STARVE_MAX)) starve_d = starve_q + SW'(1);
          end else if (bus.if_req && !bus.if_abort) begin
            state_d    = BUSY_IF;
            ext_req_d  = 1'b1;
            ext_we_d   = 1'b0;
            ext_addr_d = bus.if_addr;
            starve_d   = '0;
            abort_d    = 1'b0;
          end
        end
      end
      BUSY_IF: begin
        if (bus.if_abort) abort_d = 1'b1;
        // A flushed fetch still completes externally but is never delivered.
        if (bus.ext_ack) begin
          state_d   = IDLE;
          ext_req_d = 1'b0;
          ext_we_d  = 1'b0;
          abort_d   = 1'b0;
          if (!(abort_q || bus.if_abort)) begin
            if_rdata_d = bus.ext_rdata;
            if_ready_d = 1'b1;
          end
        end
      end
      BUSY_MEM: begin
        if (bus.ext_ack) begin
          state_d     = IDLE;
          ext_req_d   = 1'b0;
          ext_we_d    = 1'b0;
          mem_ready_d = 1'b1;
          if (!ext_we_q) mem_rdata_d = bus.ext_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ext_req_q   <= 1'b0;
      ext_we_q    <= 1'b0;
      ext_addr_q  <= '0;
      ext_wdata_q <= '0;
      if_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      mem_rdata_q <= '0;
      mem_ready_q <= 1'b0;
      starve_q    <= '0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ext_req_q   <= ext_req_d;
      ext_we_q    <= ext_we_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
      if_rdata_q  <= if_rdata_d;
      if_ready_q  <= if_ready_d;
      mem_rdata_q <= mem_rdata_d;
      mem_ready_q <= mem_ready_d;
      starve_q    <= starve_d;
      abort_q     <= abort_d;
    end
  end

  assign bus.ext_req   = ext_req_q;
  assign bus.ext_we    = ext_we_q;
  assign bus.ext_addr  = ext_addr_q;
  assign bus.ext_wdata = ext_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.mem_ready = mem_ready_q;
  assign bus.if_stall  = bus.if_req & ~if_ready_q;
  assign bus.mem_stall = mem_pend & ~mem_ready_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench plays both the pipeline and the external memory,
// acknowledging accesses by hand at chosen cycles.
module tb_mem_port_arbiter;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish (actual running, required finished)");
    $fatal(1, "[TB] timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.ext_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.if_req = 0; bus.if_addr = 0; bus.if_abort = 0;
    bus.mem_rd_en = 0; bus.mem_wr_en = 0; bus.mem_addr = 0; bus.mem_wdata = 0;
    bus.ext_rdata = 0; bus.ext_ack = 0;
    step(); step();
    checks++; if (bus.ext_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_ext_req actual=%b required=0", bus.ext_req); end
    checks++; if (bus.ext_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_ext_we actual=%b required=0", bus.ext_we); end
    checks++; if (bus.ext_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_ext_addr actual=%h required=0", bus.ext_addr); end
    checks++; if (bus.if_ready !== 1'b0 || bus.mem_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready actual=%b%b required=00", bus.if_ready, bus.mem_ready); end
    checks++; if (bus.if_rdata !== 32'h0 || bus.mem_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata actual=%h/%h required=0/0", bus.if_rdata, bus.mem_rdata); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_if_read();
    bus.if_req = 1; bus.if_addr = 32'h10;
    step();
    checks++; if (bus.ext_req !== 1'b1 || bus.ext_addr !== 32'h10 || bus.ext_we !== 1'b0) begin errors++; $display("[TB] FAIL if_grant actual req=%b addr=%h we=%b required req=1 addr=10 we=0", bus.ext_req, bus.ext_addr, bus.ext_we); end
    checks++; if (bus.if_stall !== 1'b1) begin errors++; $display("[TB] FAIL if_stall_busy actual=%b required=1", bus.if_stall); end
    step(); step();
    checks++; if (bus.ext_req !== 1'b1 || bus.ext_addr !== 32'h10) begin errors++; $display("[TB] FAIL if_hold actual req=%b addr=%h required req=1 addr=10", bus.ext_req, bus.ext_addr); end
    bus.ext_ack = 1; bus.ext_rdata = 32'hE3A01005;
    step();
    bus.ext_ack = 0; bus.ext_rdata = 32'h0;
    checks++; if (bus.if_ready !== 1'b1 || bus.if_rdata !== 32'hE3A01005) begin errors++; $display("[TB] FAIL if_ready_data actual ready=%b data=%h required ready=1 data=e3a01005", bus.if_ready, bus.if_rdata); end
    checks++; if (bus.ext_req !== 1'b0 || bus.if_stall !== 1'b0) begin errors++; $display("[TB] FAIL if_done actual req=%b stall=%b required 0 0", bus.ext_req, bus.if_stall); end
    bus.if_req = 0;
    step();
    checks++; if (bus.if_ready !== 1'b0 || bus.if_rdata !== 32'hE3A01005) begin errors++; $display("[TB] FAIL if_pulse_width actual ready=%b data=%h required ready=0 data=e3a01005", bus.if_ready, bus.if_rdata); end
    // ext_ack while idle must be ignored
    bus.ext_ack = 1;
    step();
    bus.ext_ack = 0;
    checks++; if (bus.if_ready !== 1'b0 || bus.mem_ready !== 1'b0 || bus.ext_req !== 1'b0) begin errors++; $display("[TB] FAIL idle_ack actual %b%b%b required 000", bus.if_ready, bus.mem_ready, bus.ext_req); end
  endtask

  task automatic test_priority();
    bus.if_req = 1; bus.if_addr = 32'h20;
    bus.mem_rd_en = 1; bus.mem_addr = 32'h100;
    step();
    checks++; if (bus.ext_req !== 1'b1 || bus.ext_addr !== 32'h100 || bus.ext_we !== 1'b0) begin errors++; $display("[TB] FAIL prio_mem_first actual req=%b addr=%h we=%b required 1 100 0", bus.ext_req, bus.ext_addr, bus.ext_we); end
    checks++; if (bus.if_stall !== 1'b1 || bus.mem_stall !== 1'b1) begin errors++; $display("[TB] FAIL prio_stalls actual if=%b mem=%b required 1 1", bus.if_stall, bus.mem_stall); end
    bus.ext_ack = 1; bus.ext_rdata = 32'h11112222;
    step();
    bus.ext_ack = 0;
    checks++; if (bus.mem_ready !== 1'b1 || bus.mem_rdata !== 32'h11112222 || bus.if_ready !== 1'b0) begin errors++; $display("[TB] FAIL prio_mem_done actual ready=%b data=%h ifr=%b required 1 11112222 0", bus.mem_ready, bus.mem_rdata, bus.if_ready); end
    bus.mem_rd_en = 0;
    step();
    checks++; if (bus.ext_req !== 1'b0) begin errors++; $display("[TB] FAIL prio_ready_no_grant actual=%b required=0", bus.ext_req); end
    step();
    checks++; if (bus.ext_req !== 1'b1 || bus.ext_addr !== 32'h20) begin errors++; $display("[TB] FAIL prio_if_second actual req=%b addr=%h required 1 20", bus.ext_req, bus.ext_addr); end
    bus.ext_ack = 1; bus.ext_rdata = 32'hCAFEF00D;
    step();
    bus.ext_ack = 0;
    checks++; if (bus.if_ready !== 1'b1 || bus.if_rdata !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL prio_if_done actual ready=%b data=%h required 1 cafef00d", bus.if_ready, bus.if_rdata); end
    bus.if_req = 0;
    step();
  endtask

  task automatic test_starvation();
    logic [31:0] exp_addr [0:4];
    logic ok;
    exp_addr[0] = 32'h200; exp_addr[1] = 32'h200; exp_addr[2] = 32'h200;
    exp_addr[3] = 32'h200; exp_addr[4] = 32'h30;
    bus.if_req = 1; bus.if_addr = 32'h30;
    bus.mem_rd_en = 1; bus.mem_addr = 32'h200;
    for (int g = 0; g < 5; g++) begin
      wait_grant(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL starve_grant%0d_timeout actual=no grant required=grant", g); end
      checks++; if (bus.ext_addr !== exp_addr[g]) begin errors++; $display("[TB] FAIL starve_order%0d actual addr=%h required addr=%h", g, bus.ext_addr, exp_addr[g]); end
      if (g == 4) begin
        checks++; if (dut.starve_q !== 3'd0) begin errors++; $display("[TB] FAIL starve_cleared actual=%0d required=0", dut.starve_q); end
      end
      bus.ext_rdata = (g == 4) ? 32'h0000BBBB : 32'h0000AAAA;
      bus.ext_ack = 1;
      step();
      bus.ext_ack = 0;
      if (g == 4) begin
        bus.if_req = 0;
        bus.mem_rd_en = 0;
      end
    end
    checks++; if (bus.if_ready !== 1'b1 || bus.if_rdata !== 32'h0000BBBB || bus.mem_rdata !== 32'h0000AAAA) begin errors++; $display("[TB] FAIL starve_data actual ifr=%b if=%h mem=%h required 1 0000bbbb 0000aaaa", bus.if_ready, bus.if_rdata, bus.mem_rdata); end
    step();
  endtask

  task automatic test_store();
    bus.mem_wr_en = 1; bus.mem_addr = 32'h40; bus.mem_wdata = 32'hDEADBEEF;
    step();
    checks++; if (bus.ext_req !== 1'b1 || bus.ext_we !== 1'b1 || bus.ext_addr !== 32'h40 || bus.ext_wdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL store_grant actual req=%b we=%b addr=%h wd=%h required 1 1 40 deadbeef", bus.ext_req, bus.ext_we, bus.ext_addr, bus.ext_wdata); end
    bus.mem_wdata = 32'h0; bus.ext_rdata = 32'h55555555;
    step(); step();
    checks++; if (bus.ext_wdata !== 32'hDEADBEEF || bus.ext_addr !== 32'h40 || bus.ext_we !== 1'b1) begin errors++; $display("[TB] FAIL store_stable actual wd=%h addr=%h we=%b required deadbeef 40 1", bus.ext_wdata, bus.ext_addr, bus.ext_we); end
    bus.ext_ack = 1;
    step();
    bus.ext_ack = 0;
    checks++; if (bus.mem_ready !== 1'b1 || bus.mem_rdata !== 32'h0000AAAA || bus.ext_req !== 1'b0) begin errors++; $display("[TB] FAIL store_done actual ready=%b rdata=%h req=%b required 1 0000aaaa 0", bus.mem_ready, bus.mem_rdata, bus.ext_req); end
    bus.mem_wr_en = 0;
    step();
    checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("[TB] FAIL store_pulse_width actual=%b required=0", bus.mem_ready); end
    // Read and write together behave as a write
    bus.mem_rd_en = 1; bus.mem_wr_en = 1; bus.mem_addr = 32'h44; bus.mem_wdata = 32'h12345678;
    step();
    checks++; if (bus.ext_we !== 1'b1 || bus.ext_wdata !== 32'h12345678) begin errors++; $display("[TB] FAIL rdwr_is_write actual we=%b wd=%h required 1 12345678", bus.ext_we, bus.ext_wdata); end
    bus.ext_ack = 1; bus.ext_rdata = 32'h99999999;
    step();
    bus.ext_ack = 0;
    checks++; if (bus.mem_ready !== 1'b1 || bus.mem_rdata !== 32'h0000AAAA) begin errors++; $display("[TB] FAIL rdwr_rdata_kept actual ready=%b rdata=%h required 1 0000aaaa", bus.mem_ready, bus.mem_rdata); end
    bus.mem_rd_en = 0; bus.mem_wr_en = 0;
    step();
  endtask

  task automatic test_abort();
    bus.if_req = 1; bus.if_addr = 32'h50;
    step();
    checks++; if (bus.ext_req !== 1'b1 || bus.ext_addr !== 32'h50) begin errors++; $display("[TB] FAIL abort_grant actual req=%b addr=%h required 1 50", bus.ext_req, bus.ext_addr); end
    bus.if_abort = 1;
    step();
    bus.if_abort = 0;
    checks++; if (bus.ext_req !== 1'b1) begin errors++; $display("[TB] FAIL abort_req_held actual=%b required=1", bus.ext_req); end
    step();
    bus.ext_ack = 1; bus.ext_rdata = 32'h77777777;
    step();
    bus.ext_ack = 0;
    checks++; if (bus.if_ready !== 1'b0 || bus.if_rdata !== 32'h0000BBBB || bus.ext_req !== 1'b0) begin errors++; $display("[TB] FAIL abort_suppressed actual ready=%b data=%h req=%b required 0 0000bbbb 0", bus.if_ready, bus.if_rdata, bus.ext_req); end
    bus.if_req = 0;
    step();
    // Abort in idle blocks the IF grant for that cycle only
    bus.if_req = 1; bus.if_addr = 32'h54; bus.if_abort = 1;
    step();
    checks++; if (bus.ext_req !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle_block actual=%b required=0", bus.ext_req); end
    bus.if_abort = 0;
    step();
    checks++; if (bus.ext_req !== 1'b1 || bus.ext_addr !== 32'h54) begin errors++; $display("[TB] FAIL abort_idle_regrant actual req=%b addr=%h required 1 54", bus.ext_req, bus.ext_addr); end
    bus.ext_ack = 1; bus.ext_rdata = 32'h0000CCCC;
    step();
    bus.ext_ack = 0;
    checks++; if (bus.if_ready !== 1'b1 || bus.if_rdata !== 32'h0000CCCC) begin errors++; $display("[TB] FAIL abort_after_fetch actual ready=%b data=%h required 1 0000cccc", bus.if_ready, bus.if_rdata); end
    bus.if_req = 0;
    step();
  endtask

  task automatic test_reset_mid_busy();
    bus.mem_rd_en = 1; bus.mem_addr = 32'h60;
    step();
    checks++; if (bus.ext_req !== 1'b1 || bus.ext_addr !== 32'h60) begin errors++; $display("[TB] FAIL rmid_grant actual req=%b addr=%h required 1 60", bus.ext_req, bus.ext_addr); end
    rst = 1'b1;
    #1;
    checks++; if (bus.ext_req !== 1'b0 || bus.mem_ready !== 1'b0 || bus.ext_addr !== 32'h0) begin errors++; $display("[TB] FAIL rmid_async actual req=%b ready=%b addr=%h required 0 0 0", bus.ext_req, bus.mem_ready, bus.ext_addr); end
    bus.ext_ack = 1;
    step();
    bus.ext_ack = 0; bus.mem_rd_en = 0;
    rst = 1'b0;
    step();
    checks++; if (bus.mem_ready !== 1'b0 || bus.ext_req !== 1'b0 || bus.mem_rdata !== 32'h0 || bus.if_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rmid_after actual ready=%b req=%b mem=%h if=%h required 0 0 0 0", bus.mem_ready, bus.ext_req, bus.mem_rdata, bus.if_rdata); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_if_read();
    test_priority();
    test_starvation();
    test_store();
    test_abort();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
